// File: rtl/register_file_wb_if.sv
// Writeback / decode / debug signal bundle for the RV32I integer register file.
// The master side is the pipeline (writeback drives the write, decode and
// debug drive read addresses); the slave side is the register file.
interface register_file_wb_if #(
  parameter int unsigned XLEN = 32
);
  logic            RegWriteW;
  logic [4:0]      RdW;
  logic [XLEN-1:0] ResultW;
  logic [4:0]      A1;
  logic [4:0]      A2;
  logic [XLEN-1:0] RD1;
  logic [XLEN-1:0] RD2;
  logic [4:0]      dbg_addr;
  logic [XLEN-1:0] dbg_data;
  logic [31:0]     wr_count;

  modport master (
    output RegWriteW, RdW, ResultW, A1, A2, dbg_addr,
    input  RD1, RD2, dbg_data, wr_count
  );

  modport slave (
    input  RegWriteW, RdW, ResultW, A1, A2, dbg_addr,
    output RD1, RD2, dbg_data, wr_count
  );
endinterface

// File: rtl/register_file_wb.sv
// RV32I architectural register file (x1..x31 stored, x0 hardwired to zero).
// Two combinational decode read ports with same-cycle writeback bypass, a
// non-bypassed debug read port, and a wrapping count of committed writes.
module register_file_wb #(
  parameter int unsigned     XLEN    = 32,
  parameter logic [XLEN-1:0] SP_INIT = '0
) (
  input logic               clk,
  input logic               rst_n,
  register_file_wb_if.slave wb
);

  logic [XLEN-1:0] regs_q [1:31];
  logic [XLEN-1:0] regs_d [1:31];
  logic [31:0]     wr_count_q;
  logic [31:0]     wr_count_d;

  logic            commit;
  logic [XLEN-1:0] rd1_arr;
  logic [XLEN-1:0] rd2_arr;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic [XLEN-1:0] dbg;

  // A write takes effect only when enabled, not targeting x0, and not in reset.
  always_comb begin
    commit = wb.RegWriteW && (wb.RdW != 5'd0) && rst_n;
  end

  // Next-state for storage and the write counter; reset wins over a write.
  always_comb begin
    regs_d     = regs_q;
    wr_count_d = wr_count_q;
    if (!rst_n) begin
      for (int unsigned i = 1; i < 32; i++) begin
        regs_d[i] = '0;
      end
      regs_d[2]  = SP_INIT;
      wr_count_d = '0;
    end else if (commit) begin
      for (int unsigned i = 1; i < 32; i++) begin
        if (wb.RdW == 5'(i)) begin
          regs_d[i] = wb.ResultW;
        end
      end
      wr_count_d = wr_count_q + 32'd1;
    end
  end

  // State register; reset is applied through the next-state logic.
  always_ff @(posedge clk) begin
    regs_q     <= regs_d;
    wr_count_q <= wr_count_d;
  end

  // Stored-array lookups for all three read addresses (index 0 reads zero).
  always_comb begin
    rd1_arr = '0;
    rd2_arr = '0;
    dbg     = '0;
    for (int unsigned i = 1; i < 32; i++) begin
      if (wb.A1 == 5'(i)) begin
        rd1_arr = regs_q[i];
      end
      if (wb.A2 == 5'(i)) begin
        rd2_arr = regs_q[i];
      end
      if (wb.dbg_addr == 5'(i)) begin
        dbg = regs_q[i];
      end
    end
  end

  // Decode ports see the committing writeback value in the same cycle.
  always_comb begin
    rd1 = rd1_arr;
    rd2 = rd2_arr;
    if (commit && (wb.RdW == wb.A1)) begin
      rd1 = wb.ResultW;
    end
    if (commit && (wb.RdW == wb.A2)) begin
      rd2 = wb.ResultW;
    end
  end

  assign wb.RD1      = rd1;
  assign wb.RD2      = rd2;
  assign wb.dbg_data = dbg;
  assign wb.wr_count = wr_count_q;

endmodule

// File: doc/register_file_wb.md
# register_file_wb

Architectural integer register file for the RV32I pipeline, acting as the receiving end of the writeback interface. It accepts the committed result, destination index and write enable from the writeback stage and stores them into 32 x 32-bit registers. It serves two combinational read ports to the decode stage, with write-to-read bypass, so an instruction in decode sees a value written back in the same cycle. It also exposes a debug read port and a count of retired register writes.

## Interface
Parameters:
- XLEN, 32, register width.
- SP_INIT, 32'h0000_0000, reset value of x2 (sp); every other register resets to 0.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- RegWriteW  input  1  write enable from writeback.
- RdW  input  5  destination register index from writeback.
- ResultW  input  XLEN  writeback result (ALU result, load data or PC+4).
- A1  input  5  decode read address, port 1 (rs1).
- A2  input  5  decode read address, port 2 (rs2).
- RD1  output  XLEN  read data, port 1.
- RD2  output  XLEN  read data, port 2.
- dbg_addr  input  5  debug read address.
- dbg_data  output  XLEN  debug read data, stored array only, no bypass.
- wr_count  output  32  number of committed writes to x1..x31.

## Operation
- Storage is regs[1..31]. x0 is not stored: every read of index 0 returns 0 and every write to index 0 is dropped.
- Commit condition: commit = RegWriteW && (RdW != 0) && rst_n.
- Write: when commit is true, regs[RdW] <= ResultW on the rising edge.
- Read port n (An, RDn):
  - If An == 0: RDn = 0.
  - Else if commit && RdW == An: RDn = ResultW (bypass).
  - Else: RDn = regs[An].
- Both read ports are evaluated independently. A1 == A2 == RdW returns ResultW on both ports.
- dbg_data = regs[dbg_addr] (0 for index 0). It never bypasses and never affects state.
- wr_count increments by 1 on every edge where commit is true. It wraps from 32'hFFFF_FFFF to 0. Writes to x0 and disabled writes do not count.
- Reset (rst_n low at a rising edge):
  - regs[2] <= SP_INIT, all other regs <= 0, wr_count <= 0.
  - Reset has priority over a simultaneous write; that write is lost and not counted.
  - While rst_n is low the bypass is disabled, so RDn shows stored contents.
- Undriven or X inputs on RegWriteW are not required to be handled; the pipeline guarantees clean values after reset.

## Timing
- Write latency: 1 cycle into storage. Effective read-after-write latency is 0 cycles through the bypass in the cycle the write is presented. From the next cycle onward the read comes from storage.
- RD1, RD2 and dbg_data are purely combinational from the addresses, state and writeback inputs. They have no registered delay.
- Reset values after the first rising edge with rst_n low:
  - regs = 0 except x2 = SP_INIT.
  - wr_count = 0.
  - RD1, RD2 and dbg_data therefore read 0 (or SP_INIT for index 2).
- Reset deasserted mid-stream: the first edge with rst_n high accepts a write normally.
- Back-to-back writes to the same register: the last write wins. The bypass always reflects the current-cycle ResultW.
- There is no handshake: the writeback stage presents one write per cycle and the register file accepts it unconditionally.

## Test plan
- Reset with SP_INIT=32'h0000_1000: hold rst_n low 2 cycles -> dbg_data for x2 = 32'h1000, x5 = 0, wr_count = 0, RD1 with A1=2 = 32'h1000.
- Write x5=32'hDEAD_BEEF with A1=5 in the same cycle -> RD1 = 32'hDEADBEEF combinationally in that cycle. On the next cycle with RegWriteW=0, RD1 is still 32'hDEADBEEF and wr_count = 1.
- Write x0=32'h1234_5678 with A1=A2=0 -> RD1 = RD2 = 0 in that cycle and after; wr_count unchanged.
- Write x7 = 32'h1, then x7 = 32'h2 on consecutive cycles, with A1=7 and A2=7 -> both ports show 32'h1 then 32'h2, storage ends at 32'h2, wr_count increases by 2.
- rst_n low in the same cycle as a write x9 = 32'hFFFF_FFFF with A1=9 -> RD1 = 0 during that cycle (bypass off). After the edge x9 = 0 and wr_count = 0.
- Preload wr_count to 32'hFFFF_FFFF via 2^32-1 writes (or a forced bench value), then write x3 -> wr_count = 0.
